// File: rtl/inst_buffer_pkg.sv
// Shared types and constants for the fetch-to-decode instruction buffer.
//   fetch_entry_t : one buffered instruction (pc, inst, prediction, fetch exceptions), 113 bits
//   DepthDefault  : default number of buffer entries
//   PcW/InstW/CauseW/ExcN : field widths
package inst_buffer_pkg;

    localparam int unsigned DepthDefault = 8;
    localparam int unsigned PcW          = 32;
    localparam int unsigned InstW        = 32;
    localparam int unsigned CauseW       = 7;
    localparam int unsigned ExcN         = 2;

    typedef struct packed {
        logic [PcW-1:0]                 pc;
        logic [InstW-1:0]               inst;
        logic                           pre_taken;
        logic [PcW-1:0]                 pre_addr;
        logic [ExcN-1:0]                is_exception;
        logic [ExcN-1:0][CauseW-1:0]    exception_cause;
    } fetch_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: a circular FIFO of DEPTH entries that
// accepts up to two instructions per cycle and presents the two oldest to decode.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush_i                 drop all entries (redirect); voids this cycle's handshakes
//   enq_valid_i, enq_*_i    per-slot fetch packet, slot 0 older
//   enq_ready_o             room for two entries this cycle
//   out_valid_o, out_*_o    two oldest entries, slot 0 oldest; data zero when invalid
//   out_ready_i             decode accepts slot n (slot 1 only together with slot 0)
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DepthDefault
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush_i,
    input  logic [1:0]                          enq_valid_i,
    input  logic [1:0][PcW-1:0]                 enq_pc_i,
    input  logic [1:0][InstW-1:0]               enq_inst_i,
    input  logic [1:0][PcW-1:0]                 enq_pre_addr_i,
    input  logic [1:0]                          enq_pre_taken_i,
    input  logic [1:0][ExcN-1:0]                enq_is_exception_i,
    input  logic [1:0][ExcN-1:0][CauseW-1:0]    enq_exception_cause_i,
    output logic                                enq_ready_o,
    output logic [1:0]                          out_valid_o,
    output logic [1:0][PcW-1:0]                 out_pc_o,
    output logic [1:0][InstW-1:0]               out_inst_o,
    output logic [1:0][PcW-1:0]                 out_pre_addr_o,
    output logic [1:0]                          out_pre_taken_o,
    output logic [1:0][ExcN-1:0]                out_is_exception_o,
    output logic [1:0][ExcN-1:0][CauseW-1:0]    out_exception_cause_o,
    input  logic [1:0]                          out_ready_i
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t enq_e [2];
    fetch_entry_t rd_e  [2];
    fetch_entry_t wdata0, wdata1;
    logic         we0, we1;
    logic [1:0]   n_enq, n_deq;

    // Pack per-slot inputs into entries.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            enq_e[s].pc              = enq_pc_i[s];
            enq_e[s].inst            = enq_inst_i[s];
            enq_e[s].pre_taken       = enq_pre_taken_i[s];
            enq_e[s].pre_addr        = enq_pre_addr_i[s];
            enq_e[s].is_exception    = enq_is_exception_i[s];
            enq_e[s].exception_cause = enq_exception_cause_i[s];
        end
    end

    // Handshakes and pointer/count next state.
    always_comb begin
        enq_ready_o    = (count_q <= CntW'(DEPTH - 2)) && !flush_i;
        out_valid_o[0] = (count_q >= CntW'(1)) && !flush_i;
        out_valid_o[1] = (count_q >= CntW'(2)) && !flush_i;

        n_deq = 2'd0;
        if (out_valid_o[0] && out_ready_i[0]) begin
            n_deq = (out_valid_o[1] && out_ready_i[1]) ? 2'd2 : 2'd1;
        end

        n_enq = 2'd0;
        if (enq_ready_o) begin
            n_enq = {1'b0, enq_valid_i[0]} + {1'b0, enq_valid_i[1]};
        end

        // Compaction: the first written entry is the oldest valid slot.
        we0    = enq_ready_o && (enq_valid_i != 2'b00);
        we1    = enq_ready_o && (enq_valid_i == 2'b11);
        wdata0 = enq_valid_i[0] ? enq_e[0] : enq_e[1];
        wdata1 = enq_e[1];

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PtrW'(n_deq);
            tail_d  = tail_q + PtrW'(n_enq);
            count_d = count_q + CntW'(n_enq) - CntW'(n_deq);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; count_q gates every read.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem_q[tail_q] <= wdata0;
        end
        if (we1) begin
            mem_q[tail_q + PtrW'(1)] <= wdata1;
        end
    end

    // Read the two oldest entries, zeroed when not valid.
    always_comb begin
        rd_e[0] = out_valid_o[0] ? mem_q[head_q] : '0;
        rd_e[1] = out_valid_o[1] ? mem_q[head_q + PtrW'(1)] : '0;
        for (int s = 0; s < 2; s++) begin
            out_pc_o[s]              = rd_e[s].pc;
            out_inst_o[s]            = rd_e[s].inst;
            out_pre_taken_o[s]       = rd_e[s].pre_taken;
            out_pre_addr_o[s]        = rd_e[s].pre_addr;
            out_is_exception_o[s]    = rd_e[s].is_exception;
            out_exception_cause_o[s] = rd_e[s].exception_cause;
        end
    end

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; SHALL be a power of two and at least 4.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 flush  in  1  discard all buffered entries (branch mispredict or exception redirect).
REQ-005 enq_valid  in  2  per-slot fetch packet valid; slot 0 is older.
REQ-006 enq_pc, enq_inst, enq_pre_addr  in  2x32  per-slot pc, instruction, predicted target.
REQ-007 enq_pre_taken  in  2  per-slot predicted-taken flag.
REQ-008 enq_is_exception  in  2x2  per-slot fetch-stage exception flags.
REQ-009 enq_exception_cause  in  2x2x7  per-slot fetch-stage exception causes.
REQ-010 enq_ready  out  1  buffer can accept two entries this cycle.
REQ-011 out_valid  out  2  per-slot entry presented to decode; slot 0 is oldest.
REQ-012 out_pc, out_inst, out_pre_addr, out_pre_taken, out_is_exception, out_exception_cause  out  per-slot, same widths as the enq_ fields; these feed decode pc, inst, pre_addr, pre_taken, is_exception, exception_cause.
REQ-013 out_ready  in  2  decode accepts slot n; out_ready[1] SHALL be honoured only when out_ready[0] is 1.

Function
REQ-014 Storage SHALL be a circular FIFO of DEPTH entries, one entry per instruction, each holding pc, inst, pre_taken, pre_addr, is_exception and exception_cause (113 bits).
REQ-015 State SHALL be head pointer, tail pointer (log2(DEPTH) bits, wrapping modulo DEPTH) and count (log2(DEPTH)+1 bits).
REQ-016 enq_ready SHALL be 1 exactly when count <= DEPTH-2 and flush is 0; it depends only on registered state and flush.
REQ-017 Enqueue SHALL occur only when enq_ready is 1. Valid slots are written at tail in slot order, compacted: enq_valid=2'b10 writes the slot-1 data at tail, and tail advances by popcount(enq_valid).
REQ-018 Dequeue count d SHALL be 0, 1 (out_valid[0]&out_ready[0]) or 2 (d=1 condition plus out_valid[1]&out_ready[1]); head advances by d.
REQ-019 out_valid[0] SHALL be (count>=1); out_valid[1] SHALL be (count>=2); both SHALL be 0 while flush is 1.
REQ-020 Out slot n SHALL present the entry at head+n (mod DEPTH); all out data fields SHALL be 0 when the corresponding out_valid bit is 0.
REQ-021 Latency: an entry enqueued at edge N SHALL be visible on the outputs in the cycle after edge N (one cycle); there is no bypass path from enq to out.
REQ-022 Simultaneous enqueue and dequeue SHALL both take effect: count_next = count + popcount(accepted enq) - d.
REQ-023 Flush SHALL take priority over enqueue and dequeue in the same cycle: at the next edge head=tail=0 and count=0, and enq/out handshakes in that cycle are void.
REQ-024 Ordering SHALL be preserved strictly FIFO across pointer wrap-around; the buffer SHALL never over- or underflow under any input sequence.

Reset
REQ-025 While rst_n=0: head=0, tail=0, count=0, hence out_valid=2'b00, all out data 0, enq_ready=1. Entry storage need not be reset.
REQ-026 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously); operation resumes at the first rising clk edge after rst_n returns to 1.

Structure
REQ-027 The shared package SHALL hold the entry struct type (fetch_entry_t), the DEPTH default, and the field-width constants (PC 32, INST 32, cause 7); exception-cause codes remain in the existing csr/defines headers.
REQ-028 A single flat module; no sub-module is required, storage is a register array.

Verification
REQ-029 Reset then enq_valid=2'b11 (pc 0x1c000000/0x1c000004), out_ready=0 -> next cycle out_valid=2'b11 with out_pc 0x1c000000 and 0x1c000004, count=2.
REQ-030 Enqueue pairs for 3 cycles with no dequeue, DEPTH=8 -> count=6 and enq_ready=1; after a 4th pair count=8 and enq_ready=0. A further enq_valid=2'b11 leaves count=8 and contents unchanged.
REQ-031 count=7, enq_valid=2'b11 and out_ready=2'b11 in the same cycle -> enq_ready=0, so no write occurs; count becomes 5, and the oldest two pcs leave in order.
REQ-032 enq_valid=2'b10 with pc 0x8 on an empty buffer -> next cycle out_valid=2'b01 and out_pc[0]=0x8; out_ready=2'b10 -> no dequeue.
REQ-033 Stream 20 sequential pcs through with random out_ready -> outputs in exact order across pointer wrap, with no loss or duplication.
REQ-034 flush=1 with count=5, enq_valid=2'b11, out_ready=2'b11 -> out_valid=0 that cycle, count=0 next cycle, and no flushed entry later appears; rst_n pulsed low mid-stream -> out_valid=0 immediately.
